// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: qualifies the PLL lock signal and holds the system reset
// until lock has been stable, then releases it and provides a timebase tick.
// Lock losses seen while running are counted. After too many of them the
// block latches a sticky fault that only reset can clear.
`timescale 1ns/1ps

module pll_reset_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int LOCK_STABLE   = 1024,
  parameter int RELEASE_DELAY = 16,
  parameter int TICK_DIV      = 24000,
  parameter int MAX_LOSSES    = 3
) (
  input  logic       pll_clock,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       sys_reset,
  output logic       running,
  output logic       tick,
  output logic       fault,
  output logic [7:0] lock_losses,
  output logic [2:0] state_dbg
);

  // Each counter is sized to hold its own maximum value.
  localparam int STAB_W  = $clog2(LOCK_STABLE + 1);
  localparam int DELAY_W = $clog2(RELEASE_DELAY + 1);
  localparam int TICK_W  = $clog2(TICK_DIV + 1);

  typedef enum logic [2:0] {
    ST_WAIT_LOCK = 3'd0,
    ST_STABLE    = 3'd1,
    ST_DELAY     = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [STAB_W-1:0]      r_stab_cnt;
  logic [DELAY_W-1:0]     r_delay_cnt;
  logic [TICK_W-1:0]      r_tick_cnt;
  logic [7:0]             r_losses;
  logic                   r_sys_reset;
  logic                   r_running;
  logic                   r_tick;
  logic                   r_fault;

  logic                   w_lock_s;
  state_t                 w_state_nxt;
  logic [STAB_W-1:0]      w_stab_cnt_nxt;
  logic [DELAY_W-1:0]     w_delay_cnt_nxt;
  logic [TICK_W-1:0]      w_tick_cnt_nxt;
  logic [7:0]             w_losses_nxt;
  logic [7:0]             w_losses_inc;
  logic                   w_tick_nxt;
  logic                   w_fault_hit;

  // Synchroniser chain for the asynchronous PLL lock; only its last stage is used.
  always_ff @(posedge pll_clock) begin
    if (reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign w_lock_s = r_sync[SYNC_STAGES-1];

  // Saturating increment of the loss counter, and whether it reaches the fault limit.
  assign w_losses_inc = (r_losses == 8'hFF) ? 8'hFF : (r_losses + 8'd1);
  assign w_fault_hit  = (MAX_LOSSES != 0) && (w_losses_inc == 8'(MAX_LOSSES));

  // Next-state and next-counter logic; lock loss takes priority over the tick terminal count.
  always_comb begin
    w_state_nxt     = r_state;
    w_stab_cnt_nxt  = r_stab_cnt;
    w_delay_cnt_nxt = r_delay_cnt;
    w_tick_cnt_nxt  = '0;
    w_tick_nxt      = 1'b0;
    w_losses_nxt    = r_losses;
    case (r_state)
      ST_WAIT_LOCK: begin
        if (w_lock_s) begin
          w_state_nxt    = ST_STABLE;
          w_stab_cnt_nxt = '0;
        end
      end
      ST_STABLE: begin
        if (!w_lock_s) begin
          w_state_nxt    = ST_WAIT_LOCK;
          w_stab_cnt_nxt = '0;
        end else if (r_stab_cnt == STAB_W'(LOCK_STABLE - 1)) begin
          w_state_nxt     = ST_DELAY;
          w_stab_cnt_nxt  = '0;
          w_delay_cnt_nxt = '0;
        end else begin
          w_stab_cnt_nxt = r_stab_cnt + STAB_W'(1);
        end
      end
      ST_DELAY: begin
        if (!w_lock_s) begin
          w_state_nxt     = ST_WAIT_LOCK;
          w_delay_cnt_nxt = '0;
        end else if (r_delay_cnt == DELAY_W'(RELEASE_DELAY - 1)) begin
          w_state_nxt     = ST_RUN;
          w_delay_cnt_nxt = '0;
        end else begin
          w_delay_cnt_nxt = r_delay_cnt + DELAY_W'(1);
        end
      end
      ST_RUN: begin
        if (!w_lock_s) begin
          w_losses_nxt = w_losses_inc;
          w_state_nxt  = w_fault_hit ? ST_FAULT : ST_WAIT_LOCK;
        end else begin
          // The tick is registered, so it is raised one count early to
          // land in the TICK_DIV-th cycle of each period.
          w_tick_nxt     = (r_tick_cnt == TICK_W'(TICK_DIV - 2));
          w_tick_cnt_nxt = (r_tick_cnt == TICK_W'(TICK_DIV - 1)) ?
                           '0 : (r_tick_cnt + TICK_W'(1));
        end
      end
      ST_FAULT: begin
        w_state_nxt = ST_FAULT;
      end
      default: begin
        w_state_nxt = ST_WAIT_LOCK;
      end
    endcase
  end

  // State, counters and registered outputs; outputs follow the next state so they move with it.
  always_ff @(posedge pll_clock) begin
    if (reset) begin
      r_state     <= ST_WAIT_LOCK;
      r_stab_cnt  <= '0;
      r_delay_cnt <= '0;
      r_tick_cnt  <= '0;
      r_losses    <= '0;
      r_sys_reset <= 1'b1;
      r_running   <= 1'b0;
      r_tick      <= 1'b0;
      r_fault     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_stab_cnt  <= w_stab_cnt_nxt;
      r_delay_cnt <= w_delay_cnt_nxt;
      r_tick_cnt  <= w_tick_cnt_nxt;
      r_losses    <= w_losses_nxt;
      r_sys_reset <= (w_state_nxt != ST_RUN);
      r_running   <= (w_state_nxt == ST_RUN);
      r_tick      <= w_tick_nxt;
      r_fault     <= (w_state_nxt == ST_FAULT);
    end
  end

  assign sys_reset   = r_sys_reset;
  assign running     = r_running;
  assign tick        = r_tick;
  assign fault       = r_fault;
  assign lock_losses = r_losses;
  assign state_dbg   = r_state;

endmodule
